// File: rtl/fxp64s_shift_arbiter_pkg.sv
// Shared fxp64s definitions: operand widths, field positions and the
// reference shift function used by the shifter datapath.
package fxp64s_shift_arbiter_pkg;

    localparam int FXP64S_WIDTH = 64;   // operand / result width
    localparam int FXP64S_ADDR  = 6;    // shift-amount bits that address a legal distance
    localparam int FXP64S_SIGN  = 63;   // sign bit position
    localparam int FXP64S_MAG   = 63;   // number of magnitude bits below the sign

    typedef logic [FXP64S_WIDTH-1:0] fxp64s_t;

    // Left shifts keep the sign bit and drop magnitude bits that fall off the
    // top (no saturation). Right shifts are arithmetic. Any distance of 64 or
    // more flushes the whole word, sign included.
    function automatic fxp64s_t fxp64s_shift(fxp64s_t data, fxp64s_t shift, logic sign);
        logic [FXP64S_ADDR-1:0] amt;
        logic [FXP64S_MAG-1:0]  mag;
        fxp64s_t                res;
        amt = shift[FXP64S_ADDR-1:0];
        mag = data[FXP64S_MAG-1:0] << amt;
        if (|shift[FXP64S_WIDTH-1:FXP64S_ADDR]) begin
            res = '0;
        end else if (sign) begin
            res = fxp64s_t'($signed(data) >>> amt);
        end else begin
            res = {data[FXP64S_SIGN], mag};
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp64s_shift_arbiter_if.sv
// Request/response bundle between NREQ requesters and the shared shifter.
// The arbiter uses the slave view; requesters/sink use the master view.
interface fxp64s_shift_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ*64-1:0] req_shift;
    logic [NREQ-1:0]    req_sign;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [63:0]        rsp_data;
    logic [IDW-1:0]     rsp_id;

    modport slave (
        input  req_valid, req_data, req_shift, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport master (
        output req_valid, req_data, req_shift, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/fxp64s_rr_arb.sv
// Round-robin picker: first valid requester at or above ptr, with wrap.
// grant is only driven when en is high; grant_id always names the winner.
module fxp64s_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic           found;
    int             idx;
    logic [IDW-1:0] idx_w;

    // Search NREQ positions starting at ptr; the first valid one wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IDW'(idx);
            if (!found && req_valid[idx_w]) begin
                found    = 1'b1;
                grant_id = idx_w;
            end
        end
        if (found && en) grant[grant_id] = 1'b1;
    end

endmodule

// File: rtl/fxp64s_var_shifter.sv
// Combinational fxp64s variable shifter.
module fxp64s_var_shifter
    import fxp64s_shift_arbiter_pkg::*;
(
    input  fxp64s_t data,
    input  fxp64s_t shift,
    input  logic    sign,
    output fxp64s_t result
);

    assign result = fxp64s_shift(data, shift, sign);

endmodule

// File: rtl/fxp64s_shift_arbiter.sv
// Shares one fxp64s shifter among NREQ requesters. S1 registers the granted
// operation, the shifter sits between S1 and S2, S2 drives the response.
module fxp64s_shift_arbiter
    import fxp64s_shift_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rstn,   // active-high synchronous reset
    fxp64s_shift_arbiter_if.slave    bus,
    output logic                     busy
);

    logic           s1_v_q, s1_v_d;
    fxp64s_t        s1_data_q, s1_data_d;
    fxp64s_t        s1_shift_q, s1_shift_d;
    logic           s1_sign_q, s1_sign_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_v_q, s2_v_d;
    fxp64s_t        s2_data_q, s2_data_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic            adv1, adv2, xfer;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    fxp64s_t         shift_res;
    fxp64s_t         req_data_a  [NREQ];
    fxp64s_t         req_shift_a [NREQ];

    // S2 moves when it is empty or being drained; S1 refills whenever it
    // is empty or moving on, so drain and refill can share one cycle.
    assign adv2 = s1_v_q & (~s2_v_q | bus.rsp_ready);
    assign adv1 = ~s1_v_q | adv2;

    // Ready is suppressed during reset so nothing is seen as accepted.
    fxp64s_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .en        (adv1 & ~rstn),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    assign bus.req_ready = grant;
    assign xfer          = |(bus.req_valid & grant);

    fxp64s_var_shifter u_shift (
        .data   (s1_data_q),
        .shift  (s1_shift_q),
        .sign   (s1_sign_q),
        .result (shift_res)
    );

    // Unpack the flat request buses into per-requester operands.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_data_a[i]  = bus.req_data[64*i +: 64];
            req_shift_a[i] = bus.req_shift[64*i +: 64];
        end
    end

    // Next-state for both stages and the round-robin pointer.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_data_d  = s1_data_q;
        s1_shift_d = s1_shift_q;
        s1_sign_d  = s1_sign_q;
        s1_id_d    = s1_id_q;
        s2_v_d     = s2_v_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        ptr_d      = ptr_q;

        if (adv1) begin
            s1_v_d = xfer;
            if (xfer) begin
                s1_data_d  = req_data_a[grant_id];
                s1_shift_d = req_shift_a[grant_id];
                s1_sign_d  = bus.req_sign[grant_id];
                s1_id_d    = grant_id;
            end
        end

        if (adv2) begin
            s2_v_d    = 1'b1;
            s2_data_d = shift_res;
            s2_id_d   = s1_id_q;
        end else if (bus.rsp_ready) begin
            s2_v_d = 1'b0;
        end

        if (xfer) begin
            ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rstn) begin
            s1_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s1_shift_q <= '0;
            s1_sign_q  <= 1'b0;
            s1_id_q    <= '0;
            s2_v_q     <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            ptr_q      <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_data_q  <= s1_data_d;
            s1_shift_q <= s1_shift_d;
            s1_sign_q  <= s1_sign_d;
            s1_id_q    <= s1_id_d;
            s2_v_q     <= s2_v_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.rsp_valid = s2_v_q;
    assign bus.rsp_data  = s2_data_q;
    assign bus.rsp_id    = s2_id_q;
    assign busy          = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_fxp64s_shift_arbiter.sv
// Bench for fxp64s_shift_arbiter: directed cases with literal results plus
// randomised traffic compared every cycle against a queue-based model.
module tb_fxp64s_shift_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic busy;

    always #5 clk = ~clk;

    fxp64s_shift_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    fxp64s_shift_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic done one bit position at a time.
    function automatic logic [63:0] ref_shift(logic [63:0] d, logic [63:0] s, logic sg);
        logic [63:0] r;
        r = d;
        if (s > 64'd63) return 64'h0;
        for (int k = 0; k < int'(s); k++) begin
            if (sg) r = {r[63], r[63:1]};
            else    r = {d[63], r[61:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        logic [63:0]    data;
        logic [IDW-1:0] id;
        int             acc;
    } ent_t;

    ent_t           q[$];
    int             cyc = 0;
    int             mptr = 0;
    logic           hold = 1'b0;
    logic [63:0]    hold_data;
    logic [IDW-1:0] hold_id;
    logic [NREQ-1:0] exp_rdy;
    logic           exp_v;
    logic           found;
    int             g;

    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            chk("req_ready_in_reset", bus.req_ready, 0);
            q.delete();
            mptr = 0;
            hold = 1'b0;
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = (cyc - q[0].acc) >= 2;
            chk("rsp_valid", bus.rsp_valid, exp_v);
            chk("busy", busy, q.size() > 0);
            if (hold) begin
                chk("rsp_data_stable", bus.rsp_data, hold_data);
                chk("rsp_id_stable", bus.rsp_id, hold_id);
            end
            exp_rdy = '0;
            found   = 1'b0;
            if (bus.req_valid != 0 && (q.size() < 2 || bus.rsp_ready)) begin
                for (int k = 0; k < NREQ; k++) begin
                    g = (mptr + k) % NREQ;
                    if (!found && bus.req_valid[g]) begin
                        exp_rdy[g] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("req_ready", bus.req_ready, exp_rdy);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d data %h expected no response", bus.rsp_id, bus.rsp_data);
                end else begin
                    chk("rsp_data", bus.rsp_data, q[0].data);
                    chk("rsp_id", bus.rsp_id, q[0].id);
                    void'(q.pop_front());
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    q.push_back('{ref_shift(bus.req_data[64*i +: 64], bus.req_shift[64*i +: 64], bus.req_sign[i]),
                                  IDW'(i), cyc});
                    mptr = (i + 1) % NREQ;
                end
            end
            hold      = bus.rsp_valid && !bus.rsp_ready;
            hold_data = bus.rsp_data;
            hold_id   = bus.rsp_id;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [NREQ-1:0] acc_last;

    task automatic tick();
        @(negedge clk);
        acc_last = bus.req_valid & bus.req_ready & {NREQ{~rstn}};
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc_last;
    endtask

    task automatic set_op(input int p, input logic [63:0] d, input logic [63:0] s, input logic sg);
        bus.req_data[64*p +: 64]  = d;
        bus.req_shift[64*p +: 64] = s;
        bus.req_sign[p]           = sg;
        bus.req_valid[p]          = 1'b1;
    endtask

    function automatic logic [63:0] rand_shift();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return rand64() | 64'h100;
        if (r == 1) return 64'd64 + 64'($urandom_range(0, 3));
        return 64'($urandom_range(0, 63));
    endfunction

    task automatic set_rand(input int p);
        set_op(p, rand64(), rand_shift(), 1'($urandom_range(0, 1)));
    endtask

    task automatic single_op(input int p, input logic [63:0] d, input logic [63:0] s,
                             input logic sg, input logic [63:0] exp, input string name);
        int n;
        set_op(p, d, s, sg);
        bus.rsp_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_last[p] && n < 20);
        if (!acc_last[p]) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: port %0d not accepted within 20 cycles", name, p);
            bus.req_valid[p] = 1'b0;
        end else begin
            chk({name, "_lat1_valid"}, bus.rsp_valid, 0);
            tick();
            chk({name, "_valid"}, bus.rsp_valid, 1);
            chk({name, "_data"}, bus.rsp_data, exp);
            chk({name, "_id"}, bus.rsp_id, 64'(p));
            tick();
        end
    endtask

    task automatic reset_pulse();
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.req_valid != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        if (bus.req_valid != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle: busy=%0b valid=%b after 200 cycles", name, busy, bus.req_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int nacc;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_shift = '0;
        bus.req_sign  = '0;
        bus.rsp_ready = 1'b0;
        acc_last      = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        rstn = 1'b0;

        // directed arithmetic
        single_op(1, 64'h0000_0001_0000_0000, 64'd4, 1'b0, 64'h0000_0010_0000_0000, "left4");
        single_op(0, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "right63");
        single_op(2, 64'h0000_0000_0000_1234, 64'd64, 1'b0, 64'h0, "shift64");
        single_op(3, 64'h8000_0000_0000_0001, 64'h1_0000_0000, 1'b1, 64'h0, "shift2p32");
        single_op(2, 64'hC000_0000_0000_0001, 64'd1, 1'b0, 64'h8000_0000_0000_0002, "left_drop");
        single_op(1, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b1, 64'hDEAD_BEEF_0123_4567, "shift0");

        // fairness from a fresh pointer
        reset_pulse();
        for (int i = 0; i < NREQ; i++) set_rand(i);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rr_order", acc_last, 64'(1) << (k % NREQ));
            for (int i = 0; i < NREQ; i++) if (acc_last[i]) set_rand(i);
        end
        bus.req_valid = '0;
        wait_idle("fair");

        // backpressure with three requesters
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_rand(i);
        nacc = 0;
        repeat (5) begin
            tick();
            nacc += $countones(acc_last);
        end
        chk("bp_accepts", 64'(nacc), 2);
        chk("bp_ready_zero", bus.req_ready, 0);
        chk("bp_busy", busy, 1);
        bus.rsp_ready = 1'b1;
        wait_idle("bp");

        // reset with both stages full
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_rand(i);
        repeat (3) tick();
        chk("mid_busy", busy, 1);
        chk("mid_rsp_valid", bus.rsp_valid, 1);
        rstn = 1'b1;
        tick();
        chk("post_rst_rsp_valid", bus.rsp_valid, 0);
        chk("post_rst_busy", busy, 0);
        rstn = 1'b0;
        for (int i = 0; i < NREQ; i++) set_rand(i);
        bus.rsp_ready = 1'b1;
        tick();
        chk("post_rst_first_grant", acc_last, 4'b0001);
        bus.req_valid = '0;
        wait_idle("mid");

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_rand(i);
            if (c < 1000) bus.rsp_ready = ($urandom_range(0, 3) != 0);
            else if (c < 2000) bus.rsp_ready = ($urandom_range(0, 3) == 0);
            else bus.rsp_ready = 1'b1;
            tick();
        end
        bus.rsp_ready = 1'b1;
        wait_idle("rand");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
